uart_rx_8n1: RTL and testbench
==============================

Name: uart_rx_8n1

Overview:
- Serial receiver for the byte loopback path. It recovers 8N1 UART frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) from the serial line driven by the team's transmitter.
- It presents each received byte on dout with a one-cycle done strobe.
- It sits at the far end of the tx_enable-driven transmitter, and its dout/done feed the top-level dout/done outputs.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200). Must be >= 4. Benches use 16.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- dout  output  8  last correctly framed byte; holds between frames.
- done  output  1  one-cycle pulse when dout has just been updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset, sampled on the rising clk edge while rst=1:
  - state=IDLE, dout=8'h00, done=0, frame_err=0, busy=0.
  - Counters cleared; synchronizer flops set to 1.
  - Reset mid-frame abandons the frame immediately, with no done and no frame_err.
- Input conditioning: rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s only.
- Timing reference:
  - Cycle 0 is the first edge on which the FSM in IDLE sees rx_s=0.
  - H = CLKS_PER_BIT/2 (integer division). N = CLKS_PER_BIT.
- IDLE:
  - busy=0.
  - On rx_s=0, go to START, load the counter, set busy=1.
- START:
  - At cycle H, check rx_s.
  - If rx_s=1, treat it as a glitch: return to IDLE, busy=0, no outputs.
  - If rx_s=0, go to DATA with bit index 0.
- DATA:
  - Bit i (i=0..7) is sampled at cycle H+(i+1)*N and shifted into the shift register LSB first.
  - After bit 7, go to STOP.
- STOP:
  - Sample rx_s at cycle H+9N.
  - If 1: at cycle H+9N+1, dout=shift register and done=1 for exactly one cycle. Go to IDLE.
  - If 0: at cycle H+9N+1, frame_err=1 for one cycle and dout is unchanged. Go to WAIT_IDLE.
- WAIT_IDLE:
  - Remain until rx_s=1, then go to IDLE.
  - busy stays high in this state, which prevents a break condition from being read as endless 0x00 frames.
- Back-to-back frames: the FSM is in IDLE at cycle H+9N+1, so a start edge arriving half a bit after the stop-bit centre is accepted. No gap between frames is required.
- done and frame_err are never high in the same cycle. Neither is ever high for more than one cycle.
- Counter:
  - Counts 0..N-1 and reloads on each sample point.
  - There is no wrap-around beyond N-1; the terminal-count compare is exact.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_IDLE, encoded in 3 bits);
  - DATA_BITS=8;
  - a default CLKS_PER_BIT constant, which the transmitter uses too.
- One sub-module, sync_2ff: the 1-bit two-flop synchronizer with reset value 1. It is reusable for other asynchronous inputs.
- Counter, shift register and FSM stay in uart_rx_8n1.

Test Plan (CLKS_PER_BIT=16, 10 ns clock):
1. Send 0xA5 with a correct stop bit -> exactly one done pulse about 9.5 bit periods after the start edge, dout=8'hA5, frame_err never high, busy drops with done.
2. Send 0x00 then 0xFF back-to-back with no idle gap -> two done pulses 10 bit periods apart, dout=00 then FF.
3. Drive rx low for 3 cycles, then high -> no done, no frame_err; busy high for at most H cycles, then back to IDLE; a following 0x3C frame is received correctly.
4. Send 0x5A with the stop bit forced 0, holding rx low 2 more bit periods -> one frame_err pulse, no done, dout keeps its previous value, busy stays high until rx returns to 1.
5. Assert rst for 1 cycle during data bit 4 of a frame, then send 0xC3 -> no strobe from the aborted frame, dout=00 after reset, then dout=C3 with a single done.
6. Send 0x81 with ±3% baud skew on the transmitter model -> dout=8'h81, done once.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART definitions: receiver state encoding, frame width and default bit timing.
// The transmitter pulls CLKS_PER_BIT_DEFAULT from here so both ends agree on baud.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 868;  // 100 MHz / 115200

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
// Two-flop synchronizer for a single asynchronous input; q_o lags d_i by two clocks.
// Reset value is a parameter so idle-high lines come out of reset inactive.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_8n1.sv
`timescale 1ns/1ps
// 8N1 UART receiver: mid-bit sampling of a synchronized line, byte + done strobe out.
// Byte appears H+9N+1 clocks after the FSM sees the start edge; no backpressure (done is a pulse).
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int BIDX_W = $clog2(DATA_BITS);

    // Counter is loaded with 0 on the edge that enters a phase, so the edge
    // that sees count k is k+1 cycles into that phase.
    localparam logic [CNT_W-1:0]  HALF_TC  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_TC  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic [BIDX_W-1:0]      bidx_q,  bidx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   dout_q,  dout_d;
    logic                   done_q,  done_d;
    logic                   ferr_q,  ferr_d;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bidx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bidx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bidx_d = bidx_q + BIDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        dout_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Holding here until the line idles keeps a break from decoding as 0x00 frames.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_8n1 at 16 clocks per bit with a 10 ns clock.
module tb_uart_rx_8n1;

    localparam int N      = 16;
    localparam int H      = N / 2;
    localparam int BIT_NS = N * 10;
    // Line edge to done: 2 synchronizer flops + 1 edge for the FSM to see it, then H+9N.
    localparam int LAT    = 3 + H + 9 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] dout;
    logic       done;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    uart_rx_8n1 #(
        .CLKS_PER_BIT (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .dout      (dout),
        .done      (done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event recorder, sampled mid-cycle.
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         viol     = 0;
    int         done_cyc_q[$];
    logic [7:0] done_val_q[$];
    logic       busy_at_done_q[$];
    logic       busy_before_q[$];
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic       prev_busy = 1'b0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc_q.push_back(cyc);
            done_val_q.push_back(dout);
            busy_at_done_q.push_back(busy);
            busy_before_q.push_back(prev_busy);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if ((done === 1'b1 && frame_err === 1'b1) ||
            (done === 1'b1 && prev_done) || (frame_err === 1'b1 && prev_ferr))
            viol++;
        prev_done = (done === 1'b1);
        prev_ferr = (frame_err === 1'b1);
        prev_busy = (busy === 1'b1);
    end

    // Reference: a good frame yields its byte, a low stop bit yields a frame error only.
    logic [7:0] exp_dout = 8'h00;

    // Drives one frame; leaves rx at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
        rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_ns);
        end
        rx = stop;
        #(bit_ns);
    endtask

    task automatic align(output int start_cyc);
        @(posedge clk);
        #1;
        start_cyc = cyc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (dout !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h exp=00", dout); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single;
        int s, d0, f0, q0;
        d0 = done_cnt; f0 = ferr_cnt; q0 = done_cyc_q.size();
        align(s);
        send_frame(8'hA5, 1'b1, BIT_NS);
        exp_dout = 8'hA5;
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL a5_done_count got=%0d exp=1", done_cnt - d0); end
        total++; if (dout !== exp_dout) begin bad++; $display("FAIL a5_dout got=%h exp=%h", dout, exp_dout); end
        total++; if (ferr_cnt - f0 != 0) begin bad++; $display("FAIL a5_ferr got=%0d exp=0", ferr_cnt - f0); end
        if (done_cyc_q.size() > q0) begin
            total++; if (done_cyc_q[q0] - s != LAT) begin bad++; $display("FAIL a5_latency got=%0d exp=%0d", done_cyc_q[q0] - s, LAT); end
            total++; if (busy_at_done_q[q0] !== 1'b0 || busy_before_q[q0] !== 1'b1) begin
                bad++; $display("FAIL a5_busy_drop got=%b%b exp=10", busy_before_q[q0], busy_at_done_q[q0]); end
        end
    endtask

    task automatic test_back_to_back;
        int s, d0, q0;
        d0 = done_cnt; q0 = done_cyc_q.size();
        align(s);
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
        exp_dout = 8'hFF;
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - d0); end
        if (done_cyc_q.size() >= q0 + 2) begin
            total++; if (done_val_q[q0] !== 8'h00) begin bad++; $display("FAIL b2b_first got=%h exp=00", done_val_q[q0]); end
            total++; if (done_val_q[q0+1] !== 8'hFF) begin bad++; $display("FAIL b2b_second got=%h exp=ff", done_val_q[q0+1]); end
            total++; if (done_cyc_q[q0+1] - done_cyc_q[q0] != 10 * N) begin
                bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", done_cyc_q[q0+1] - done_cyc_q[q0], 10 * N); end
        end
    endtask

    task automatic test_glitch;
        int s, d0, f0, busy_cycles;
        d0 = done_cnt; f0 = ferr_cnt; busy_cycles = 0;
        align(s);
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * N) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        total++; if (busy_cycles < 1 || busy_cycles > H) begin bad++; $display("FAIL glitch_busy got=%0d exp=1..%0d", busy_cycles, H); end
        total++; if (done_cnt - d0 != 0 || ferr_cnt - f0 != 0) begin
            bad++; $display("FAIL glitch_strobes got=%0d/%0d exp=0/0", done_cnt - d0, ferr_cnt - f0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_idle got=%b exp=0", busy); end
        d0 = done_cnt;
        align(s);
        send_frame(8'h3C, 1'b1, BIT_NS);
        exp_dout = 8'h3C;
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 1 || dout !== exp_dout) begin
            bad++; $display("FAIL glitch_next got=%0d/%h exp=1/%h", done_cnt - d0, dout, exp_dout); end
    endtask

    task automatic test_frame_err;
        int s, d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        align(s);
        send_frame(8'h5A, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%b exp=1", busy); end
        total++; if (ferr_cnt - f0 != 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0); end
        total++; if (done_cnt - d0 != 0) begin bad++; $display("FAIL ferr_no_done got=%0d exp=0", done_cnt - d0); end
        #1 rx = 1'b1;
        repeat (6) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_release got=%b exp=0", busy); end
        total++; if (dout !== exp_dout) begin bad++; $display("FAIL ferr_dout_kept got=%h exp=%h", dout, exp_dout); end
    endtask

    task automatic test_random;
        int s, d0, f0, q0, exp_ferr;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        logic       stop;
        d0 = done_cnt; f0 = ferr_cnt; q0 = done_val_q.size(); exp_ferr = 0;
        align(s);
        for (int i = 0; i < 8; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, BIT_NS);
            if (stop) begin
                exp_q.push_back(b);
                exp_dout = b;
            end else begin
                exp_ferr++;
                rx = 1'b1;
                #(BIT_NS);
            end
            #($urandom_range(0, 5) * 10);
        end
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != exp_q.size()) begin bad++; $display("FAIL rand_done_count got=%0d exp=%0d", done_cnt - d0, exp_q.size()); end
        total++; if (ferr_cnt - f0 != exp_ferr) begin bad++; $display("FAIL rand_ferr_count got=%0d exp=%0d", ferr_cnt - f0, exp_ferr); end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (done_val_q.size() > q0 + i) begin
                total++; if (done_val_q[q0+i] !== exp_q[i]) begin bad++; $display("FAIL rand_byte%0d got=%h exp=%h", i, done_val_q[q0+i], exp_q[i]); end
            end
        end
        total++; if (dout !== exp_dout) begin bad++; $display("FAIL rand_dout got=%h exp=%h", dout, exp_dout); end
    endtask

    task automatic test_reset_mid;
        int s, d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        align(s);
        // Upper nibble of the aborted byte is all ones so its tail cannot look like a start bit.
        fork
            send_frame(8'hF5, 1'b1, BIT_NS);
            begin
                #(5 * BIT_NS + BIT_NS / 2);
                @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        exp_dout = 8'h00;
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 0 || ferr_cnt - f0 != 0) begin
            bad++; $display("FAIL rstmid_strobes got=%0d/%0d exp=0/0", done_cnt - d0, ferr_cnt - f0); end
        total++; if (dout !== exp_dout) begin bad++; $display("FAIL rstmid_dout got=%h exp=%h", dout, exp_dout); end
        align(s);
        send_frame(8'hC3, 1'b1, BIT_NS);
        exp_dout = 8'hC3;
        repeat (8) @(negedge clk);
        total++; if (done_cnt - d0 != 1 || dout !== exp_dout) begin
            bad++; $display("FAIL rstmid_next got=%0d/%h exp=1/%h", done_cnt - d0, dout, exp_dout); end
    endtask

    task automatic test_skew;
        int s, d0;
        int periods[2];
        periods[0] = 165;
        periods[1] = 155;
        for (int k = 0; k < 2; k++) begin
            d0 = done_cnt;
            align(s);
            send_frame(8'h81, 1'b1, periods[k]);
            exp_dout = 8'h81;
            repeat (12) @(negedge clk);
            total++; if (done_cnt - d0 != 1 || dout !== exp_dout) begin
                bad++; $display("FAIL skew_%0dns got=%0d/%h exp=1/%h", periods[k], done_cnt - d0, dout, exp_dout); end
        end
    endtask

    task automatic test_strobe_rules;
        total++; if (viol != 0) begin bad++; $display("FAIL strobe_rules got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_glitch;
        test_frame_err;
        test_random;
        test_reset_mid;
        test_skew;
        test_strobe_rules;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
